// File: rtl/seq_det_pkg.sv
// Shared definitions for the Moore sequence detector: FSM state width,
// state encodings and a small helper used by the next-state logic.
package seq_det_pkg;

    // Width of the FSM state register and of the debug state output.
    localparam int STATE_W = 2;

    typedef logic [STATE_W-1:0] state_t;

    // State encodings; 2'd3 is unreachable and recovers to IDLE.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_HIT     = 2'd2;
    localparam logic [1:0] ST_ILLEGAL = 2'd3;

    // True in the states where sampled bits are consumed.
    function automatic logic is_searching(input state_t s);
        return (s == ST_ARMED) || (s == ST_HIT);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear. Clear wins over increment;
// once all ones the count holds until cleared or reset.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,    // asynchronous, active-low
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q,
    output logic         sat
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;
    logic         sat_w;

    assign sat_w = &q_q;

    // Next count: clear first, then increment unless already saturated.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && !sat_w) begin
            q_d = q_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q   = q_q;
    assign sat = sat_w;

endmodule

// File: rtl/seq_detect_moore.sv
// Moore serial pattern detector. A load strobe captures the target pattern
// and arms the search; sampled bits (en=1) shift into a history register and
// a fill counter tracks how many valid bits it holds. A full history equal to
// the pattern moves the FSM to HIT, which drives y for one cycle per match.
// Legal parameter ranges: PAT_W 2..16, CNT_W 1..32, OVERLAP 0 or 1.
module seq_detect_moore
    import seq_det_pkg::*;
#(
    parameter int PAT_W   = 4,
    parameter int CNT_W   = 8,
    parameter int OVERLAP = 1
) (
    input  logic             clk,
    input  logic             rst,        // asynchronous, active-low
    input  logic             en,
    input  logic             w,
    input  logic             load,
    input  logic [PAT_W-1:0] pattern,
    input  logic             clr,
    output logic             y,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat,
    output logic [1:0]       state_o
);

    // fill counts 0..PAT_W inclusive, so it needs one extra code point.
    localparam int               FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    state_t             state_q, state_d;
    logic [PAT_W-1:0]   pat_q,   pat_d;
    logic [PAT_W-1:0]   hist_q,  hist_d;
    logic [FILL_W-1:0]  fill_q,  fill_d;

    logic [PAT_W-1:0]   hist_shift;
    logic [FILL_W-1:0]  fill_inc;
    logic               consume;
    logic               match;

    // Post-shift view of the history and fill used by the match test.
    always_comb begin
        hist_shift = {hist_q[PAT_W-2:0], w};
        fill_inc   = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
        consume    = is_searching(state_q) && en && !load;
        match      = consume && (fill_inc == FILL_FULL) && (hist_shift == pat_q);
    end

    // Next-state logic: load overrides everything, IDLE waits for load,
    // the searching states consume bits, the illegal code drops to IDLE.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        if (load) begin
            pat_d   = pattern;
            hist_d  = '0;
            fill_d  = '0;
            state_d = ST_ARMED;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_ARMED, ST_HIT: begin
                    if (en) begin
                        hist_d = hist_shift;
                        // Non-overlapping search needs PAT_W fresh bits after a hit.
                        if (match && (OVERLAP == 0)) begin
                            fill_d = '0;
                        end else begin
                            fill_d = fill_inc;
                        end
                    end
                    state_d = match ? ST_HIT : ST_ARMED;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // FSM, pattern and history registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            hist_q  <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .inc (match),
        .clr (clr),
        .q   (match_cnt),
        .sat (cnt_sat)
    );

    assign y       = (state_q == ST_HIT);
    assign state_o = state_q;

endmodule

// File: doc/seq_detect_moore.md
SEQ_DETECT_MOORE -- requirements
Module: seq_detect_moore

Interface
REQ-001 The block SHALL have parameter PAT_W, default 4, pattern length in bits, legal range 2..16.
REQ-002 The block SHALL have parameter CNT_W, default 8, match counter width, legal range 1..32.
REQ-003 The block SHALL have parameter OVERLAP, default 1; 1 allows overlapping matches, 0 restarts the search after each match.
REQ-004 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port en  input  1  sample strobe; w is consumed only when en=1.
REQ-007 The block SHALL have port w  input  1  serial data bit.
REQ-008 The block SHALL have port load  input  1  one-cycle strobe that captures pattern and re-arms the detector.
REQ-009 The block SHALL have port pattern  input  PAT_W  target sequence; pattern[PAT_W-1] is the first bit expected.
REQ-010 The block SHALL have port clr  input  1  synchronous clear of match_cnt.
REQ-011 The block SHALL have port y  output  1  Moore detect flag, high only in state HIT.
REQ-012 The block SHALL have port match_cnt  output  CNT_W  number of matches since reset/clr, saturating.
REQ-013 The block SHALL have port cnt_sat  output  1  high when match_cnt is all ones.
REQ-014 The block SHALL have port state_o  output  2  current FSM state for debug.

Function
REQ-015 The FSM SHALL have states IDLE=0, ARMED=1, HIT=2; encoding 3 is illegal and SHALL return to IDLE on the next edge.
REQ-016 In IDLE, en/w SHALL be ignored; the FSM SHALL stay in IDLE until load=1.
REQ-017 When load=1 in any state, pat_reg SHALL capture pattern, hist and fill SHALL clear to 0, and the next state SHALL be ARMED; load SHALL take priority over en in the same cycle.
REQ-018 In ARMED or HIT with en=1 and load=0, hist SHALL shift left with w as the new LSB, and fill SHALL increment, saturating at PAT_W.
REQ-019 A match SHALL be the condition (post-shift fill == PAT_W) and (post-shift hist == pat_reg); a match SHALL set next state to HIT.
REQ-020 From ARMED or HIT, en=1 without a match, or en=0, SHALL set next state to ARMED.
REQ-021 y SHALL be a pure function of state (Moore); y SHALL rise in the cycle after the edge that samples the completing bit (latency 1 cycle).
REQ-022 With OVERLAP=1, hist/fill SHALL be retained on a match, so back-to-back matches keep y high for consecutive cycles.
REQ-023 With OVERLAP=0, fill SHALL clear to 0 on a match, so the next match requires PAT_W fresh sampled bits.
REQ-024 match_cnt SHALL increment by 1 on every edge where a match occurs and SHALL hold at 2^CNT_W-1 without wrapping.
REQ-025 clr=1 SHALL set match_cnt to 0, taking priority over a simultaneous match increment.
REQ-026 load SHALL NOT modify match_cnt.

Reset
REQ-027 While rst=0, state SHALL be IDLE, y=0, match_cnt=0, cnt_sat=0, hist=0, fill=0, pat_reg=0, state_o=0, asynchronously.
REQ-028 Reset asserted mid-sequence SHALL discard any partial match; after release a load SHALL be required before detection resumes.

Structure
REQ-029 The state encodings (IDLE, ARMED, HIT) and the 2-bit state width SHALL be defined in shared package seq_det_pkg.
REQ-030 The saturating counter SHALL be a sub-module sat_counter (parameter W; inputs clk, rst, inc, clr; outputs q, sat).

Verification
REQ-031 The bench SHALL reset, then drive en=1 with w=1 and no load -> y=0, state_o=0, and match_cnt=0 throughout.
REQ-032 The bench SHALL drive PAT_W=4, OVERLAP=1, load pattern=4'b1011, then stream 1,0,1,1,0,1,1 (en=1) -> y high the cycle after bit 4 and after bit 7, and match_cnt=2.
REQ-033 The bench SHALL repeat the same stream with OVERLAP=0 -> y high only after bit 4, and match_cnt=1.
REQ-034 The bench SHALL use CNT_W=2 with pattern 4'b1111 and stream seven 1s (OVERLAP=1) -> match_cnt goes 1,2,3,3, cnt_sat=1, and y high for 4 consecutive cycles.
REQ-035 The bench SHALL assert clr coincident with a match -> match_cnt=0 while y=1 the next cycle; it SHALL also assert load coincident with en=1 on a completing bit -> no match, state ARMED, fill=0.
REQ-036 The bench SHALL drop rst after bits 1,0,1 of pattern 1011 -> immediate IDLE with all outputs 0; after release, a stream of 1 with no load SHALL produce no y.
